// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// The source is picked by an external select or by round-robin arbitration.
module stream_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    logic             load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] ptr;
    logic             hi_found;
    logic [SEL_W-1:0] hi_idx;
    logic             lo_found;
    logic [SEL_W-1:0] lo_idx;

    assign load = !out_valid || out_ready;

    // Round-robin search, split into two scans so no modulo is needed:
    // the lowest requester above ptr wins, otherwise the lowest at or below it.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                if (i > int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (!mode) begin
            grant = sel;
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    grant_valid = 1'b1;
                end
            end
        end else begin
            grant       = hi_found ? hi_idx : lo_idx;
            grant_valid = hi_found || lo_found;
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(grant) == i) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                // in_ready is held low while reset is asserted.
                in_ready[i] = rst_n && load && grant_valid;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SEL_W'(CHANNELS - 1);
        end else if (load && grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant;
            ptr       <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a 4-channel instance for the main scenarios
// and a 3-channel instance for out-of-range select and non-power-of-two wrap.
module tb_stream_mux;

    localparam int W    = 8;
    localparam int CH_A = 4;
    localparam int CH_B = 3;
    localparam int SW_A = 2;
    localparam int SW_B = 2;

    logic clk;
    logic rst_n;

    logic                 a_mode;
    logic [SW_A-1:0]      a_sel;
    logic [CH_A-1:0]      a_in_valid;
    logic [CH_A*W-1:0]    a_in_data;
    logic [CH_A-1:0]      a_in_ready;
    logic                 a_out_valid;
    logic [W-1:0]         a_out_data;
    logic [SW_A-1:0]      a_out_chan;
    logic                 a_out_ready;

    logic                 b_mode;
    logic [SW_B-1:0]      b_sel;
    logic [CH_B-1:0]      b_in_valid;
    logic [CH_B*W-1:0]    b_in_data;
    logic [CH_B-1:0]      b_in_ready;
    logic                 b_out_valid;
    logic [W-1:0]         b_out_data;
    logic [SW_B-1:0]      b_out_chan;
    logic                 b_out_ready;

    int checks   = 0;
    int failures = 0;

    stream_mux #(.WIDTH(W), .CHANNELS(CH_A)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (a_mode),
        .sel       (a_sel),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_chan  (a_out_chan),
        .out_ready (a_out_ready)
    );

    stream_mux #(.WIDTH(W), .CHANNELS(CH_B)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (b_mode),
        .sel       (b_sel),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_chan  (b_out_chan),
        .out_ready (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ch;

        rst_n       = 1'b0;
        a_mode      = 1'b0;
        a_sel       = '0;
        a_in_valid  = 4'b1111;
        a_in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        a_out_ready = 1'b0;
        b_mode      = 1'b0;
        b_sel       = '0;
        b_in_valid  = '0;
        b_in_data   = {8'hA2, 8'hA1, 8'hA0};
        b_out_ready = 1'b0;

        // Reset state, including in_ready gated low despite valid inputs.
        #2;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data",  32'(a_out_data),  32'h0);
        check("rst_out_chan",  32'(a_out_chan),  32'd0);
        check("rst_in_ready",  32'(a_in_ready),  32'h0);
        a_out_ready = 1'b1;
        step();
        check("rst_in_ready_held", 32'(a_in_ready), 32'h0);
        check("rst_out_valid_held", 32'(a_out_valid), 32'd0);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);

        // Manual select stepping through all channels.
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            a_sel = SW_A'(s);
            #1;
            check("man_in_ready", 32'(a_in_ready), 32'(1 << s));
            step();
            check("man_out_valid", 32'(a_out_valid), 32'd1);
            check("man_out_data",  32'(a_out_data),  32'(8'h11 * (s + 1)));
            check("man_out_chan",  32'(a_out_chan),  32'(s));
        end

        // Selected channel not valid: no grant, register drains.
        a_sel      = 2'd2;
        a_in_valid = 4'b1011;
        #1;
        check("man_nogrant_in_ready", 32'(a_in_ready), 32'h0);
        step();
        check("man_nogrant_out_valid", 32'(a_out_valid), 32'd0);
        check("man_nogrant_data_kept", 32'(a_out_data),  32'h44);

        // Round-robin, all channels valid.
        a_mode     = 1'b1;
        a_in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            ch = k % 4;
            #1;
            check("rr_in_ready", 32'(a_in_ready), 32'(1 << ch));
            step();
            check("rr_out_valid", 32'(a_out_valid), 32'd1);
            check("rr_out_chan",  32'(a_out_chan),  32'(ch));
            check("rr_out_data",  32'(a_out_data),  32'(8'h11 * (ch + 1)));
        end

        // Round-robin with only ch1 and ch3 requesting.
        a_in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            ch = (k % 2 == 0) ? 1 : 3;
            #1;
            check("rr_sparse_in_ready", 32'(a_in_ready), 32'(1 << ch));
            step();
            check("rr_sparse_out_chan", 32'(a_out_chan), 32'(ch));
            check("rr_sparse_out_data", 32'(a_out_data), 32'(8'h11 * (ch + 1)));
        end

        // Backpressure: held word stays put, nothing accepted.
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(a_in_ready), 32'h0);
            step();
            check("bp_out_valid", 32'(a_out_valid), 32'd1);
            check("bp_out_data",  32'(a_out_data),  32'h44);
            check("bp_out_chan",  32'(a_out_chan),  32'd3);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(a_in_ready), 32'h1);
        step();
        check("bp_release_out_valid", 32'(a_out_valid), 32'd1);
        check("bp_release_out_chan",  32'(a_out_chan),  32'd0);
        check("bp_release_out_data",  32'(a_out_data),  32'h11);

        // Asynchronous reset while a word is held.
        a_out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(a_out_valid), 32'd0);
        check("midrst_out_data",  32'(a_out_data),  32'h0);
        check("midrst_out_chan",  32'(a_out_chan),  32'd0);
        check("midrst_in_ready",  32'(a_in_ready),  32'h0);
        step();
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        #1;
        check("midrst_first_in_ready", 32'(a_in_ready), 32'h1);
        step();
        check("midrst_first_out_chan",  32'(a_out_chan),  32'd0);
        check("midrst_first_out_valid", 32'(a_out_valid), 32'd1);

        // Three-channel build: out-of-range select never grants.
        b_mode      = 1'b0;
        b_sel       = 2'd3;
        b_in_valid  = 3'b111;
        b_out_ready = 1'b1;
        #1;
        check("b_sel3_in_ready", 32'(b_in_ready), 32'h0);
        step();
        check("b_sel3_out_valid", 32'(b_out_valid), 32'd0);
        step();
        check("b_sel3_out_valid_2", 32'(b_out_valid), 32'd0);

        // Three-channel round-robin wraps 2 -> 0.
        b_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ch = k % 3;
            #1;
            check("b_rr_in_ready", 32'(b_in_ready), 32'(1 << ch));
            step();
            check("b_rr_out_chan", 32'(b_out_chan), 32'(ch));
            check("b_rr_out_data", 32'(b_out_data), 32'(8'hA0 + ch));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel stream multiplexer with registered output and valid/ready handshakes on every port. Generalises the fixed 4:1 select mux to CHANNELS inputs of WIDTH bits. Selection is either manual (external select) or round-robin arbitration. Sits between multiple producer streams and a single consumer, e.g. merging per-lane data onto one bus.

## Interface
- WIDTH, 8, data width per channel (>=1)
- CHANNELS, 4, number of input channels (>=2, power of two not required)
- SEL_W, derived localparam = max(1, clog2(CHANNELS)), select/channel-index width
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset: asynchronous assert, active-low
- mode  input  1  0 = manual select, 1 = round-robin
- sel  input  SEL_W  channel index used in manual mode
- in_valid  input  CHANNELS  per-channel valid, bit i = channel i
- in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_ready  output  CHANNELS  per-channel ready, one-hot or zero
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  held word
- out_chan  output  SEL_W  source channel index of held word
- out_ready  input  1  consumer accepts word when out_valid && out_ready

## Operation
- State: output register (out_valid, out_data, out_chan) and round-robin pointer ptr (SEL_W bits, last granted channel).
- load = !out_valid || out_ready (register empty or draining this cycle).
- Grant, combinational:
  - mode=0: grant = sel, grant_valid = (sel < CHANNELS) && in_valid[sel]. sel >= CHANNELS never grants.
  - mode=1: first i with in_valid[i] set, searching cyclically from ptr+1 (wrap CHANNELS-1 -> 0); grant_valid = |in_valid.
- in_ready[i] = load && grant_valid && (grant == i). At most one bit set. in_ready depends combinationally on out_ready, in_valid, mode, sel.
- Input transfer on channel g when in_valid[g] && in_ready[g]: at next edge out_data <= in_data[g], out_chan <= g, out_valid <= 1, ptr <= g (both modes).
- Output transfer (out_valid && out_ready) with no input transfer in same cycle: out_valid <= 0; out_data/out_chan retain last values.
- Simultaneous output and input transfer: register replaced by new word, out_valid stays 1 (full throughput, one word/cycle).
- out_valid && !out_ready: out_valid, out_data, out_chan held stable; all in_ready low.
- Non-granted valid inputs are stalled (must hold data); no word is dropped or duplicated.
- mode/sel changes take effect in the same cycle's grant; no internal state besides ptr is affected.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1 (first round-robin grant goes to channel 0). in_ready all 0 while in reset.
- Latency: input word accepted at edge N appears on out_data/out_valid after edge N (visible cycle N+1).
- Throughput: 1 word/cycle with out_ready held high.
- Reset mid-operation: held word discarded, out_valid drops immediately (async), ptr reset; first grant after deassertion from channel 0 in mode=1.
- Round-robin fairness: with all CHANNELS valid and out_ready=1, grants cycle 0,1,...,CHANNELS-1,0,... with no channel granted twice before every other requesting channel once.

## Test plan
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately; all in_ready=0.
- Manual mode, CHANNELS=4, WIDTH=8: in_data ch0..3 = 0x11,0x22,0x33,0x44 all valid, out_ready=1, sel stepping 0,1,2,3 per cycle -> out_data 0x11,0x22,0x33,0x44 one cycle later each, out_chan 0..3; sel=2 with in_valid[2]=0 -> in_ready=0, out_valid drops.
- Round-robin, all valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3; exactly one in_ready bit high per cycle.
- Round-robin sparse: only ch1 and ch3 valid -> out_chan alternates 1,3,1,3; ch0/ch2 in_ready stay 0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_chan stable, in_ready all 0; out_ready=1 next cycle -> word consumed and new word loaded same edge, out_valid remains 1.
- CHANNELS=3 build, manual mode sel=3 with all valid -> no grant, out_valid stays 0; mode=1 -> grants 0,1,2,0 wrap.
